sram_result_writer: RTL and testbench
=====================================

// Module: sram_result_writer
// PURPOSE
//  Write-side SRAM controller for the AES datapath.
//  - Accepts 128-bit result blocks from the AES core over a valid/ready handshake.
//  - Serialises each block into 16 byte writes to SRAM, from s_addr up to loc (inclusive).
//  - Flags completion on done.
//  - Counterpart of the read-side SRAM controller that feeds the core.
// PARAMETERS
//  ADDR_BITS    8   SRAM address width; address arithmetic is modulo 2**ADDR_BITS
//  BLOCK_BYTES  16  bytes per AES block; must equal width(blk_data)/8
// PORTS
//  clk        in   1          system clock, rising edge
//  n_rst      in   1          asynchronous reset, active low
//  enable     in   1          level; high = run, low = abort/idle
//  s_addr     in   ADDR_BITS  first write address, sampled on IDLE->WAIT_BLK
//  loc        in   ADDR_BITS  last write address (inclusive), sampled with s_addr
//  blk_valid  in   1          AES core presents a result block
//  blk_data   in   128        result block, byte [127:120] written first
//  blk_ready  out  1          writer can take a block this cycle
//  sram_wait  in   1          SRAM stall; holds current write when high
//  w_en       out  1          SRAM write strobe
//  w_addr     out  ADDR_BITS  SRAM write address
//  w_data     out  8          SRAM write byte
//  done       out  1          write of address loc accepted; held until enable low
//  trunc      out  1          loc reached before block end; valid with done
// BEHAVIOUR
//  Reset: state IDLE; all outputs and internal registers 0.
//  All outputs are registered or decoded from state/registers only; no input->output comb paths.
//  Transfers
//  - Block transfer occurs on the cycle blk_valid && blk_ready.
//  - A byte write is accepted on the cycle w_en && !sram_wait.
//  States
//  - IDLE: when enable=1, latch ptr<=s_addr and end<=loc, then go to WAIT_BLK.
//  - WAIT_BLK: blk_ready=1.
//    On block transfer, load shift reg, cnt<=0, go to WRITE.
//    First w_en appears the following cycle.
//  - WRITE: w_en=1, w_addr=ptr, w_data=shift[127:120].
//    On an accepted write: ptr++, cnt++, shift<<=8.
//    If ptr==end: go to DONE; trunc=1 if cnt!=BLOCK_BYTES-1 (remaining bytes dropped).
//    Else if cnt==BLOCK_BYTES-1: go to WAIT_BLK.
//    sram_wait=1: hold w_en/w_addr/w_data unchanged.
//  - DONE: done=1, w_en=0, blk_ready=0.
//    Hold until enable=0, then go to IDLE and clear done/trunc.
//  Limits
//  - Throughput: 1 byte/cycle with no stalls.
//  - Block-to-block gap: 1 cycle (WAIT_BLK).
//  Boundaries
//  - enable=0 in any state: go to IDLE next cycle; w_en and blk_ready deassert.
//    A partially written block is discarded.
//  - ptr wraps 2**ADDR_BITS-1 -> 0, so s_addr>loc writes through the wrap.
//  - s_addr==loc: exactly one byte is written, then DONE with trunc=1.
//  - blk_valid while not in WAIT_BLK: ignored, no transfer.
//  - n_rst low mid-write: immediate return to reset values; no SRAM write completes.
// CONFIGURATION
//  SRAM_WR_PARITY_EN defined:
//  - Adds output w_par (1 bit): even parity of w_data, registered with w_data.
//  - Parity is 0 at reset.
//  Undefined: no w_par port; behaviour otherwise identical.
// STRUCTURE
//  Package aes_sram_pkg:
//  - wr_state_t enum {IDLE, WAIT_BLK, WRITE, DONE}
//  - BLOCK_BYTES and AES_BLOCK_W=128 constants
//  Sub-module blk_shift_reg: 128-bit load/shift-by-8 register; load, shift, byte_out.
//  FSM, ptr/cnt counters and compare logic stay in the top module.
// TESTING
//  1. s_addr=0x00, loc=0x0F, one block 0x00112233..FF.
//     -> 16 writes at addr 0x00..0x0F with data 00,11,..,FF.
//     -> done=1, trunc=0, blk_ready low after the transfer.
//  2. s_addr=0x10, loc=0x2F, two blocks back to back.
//     -> 32 writes, 1-cycle gap between blocks, done=1 after the write to 0x2F.
//  3. s_addr=0xF8, loc=0x07, one block.
//     -> writes at 0xF8..0xFF then 0x00..0x07, done=1.
//  4. sram_wait high for 3 cycles at the 5th byte.
//     -> w_addr/w_data frozen for those cycles, no skipped or duplicated address.
//  5. s_addr=0x40, loc=0x44, one block.
//     -> 5 writes, done=1, trunc=1; further blk_valid is ignored.
//  6. enable dropped after 7th byte, then re-raised with s_addr=0x80.
//     -> w_en=0 next cycle, IDLE, restart writes at 0x80.
//  7. Macro SRAM_WR_PARITY_EN defined, w_data=0x07.
//     -> w_par=1 in the same cycle as w_data.

Source files
------------

// File: rtl/aes_sram_pkg.sv
// Shared types and constants for the AES SRAM write-side controller.
//   wr_state_t  : write FSM states
//   AES_BLOCK_W : width of one AES result block in bits
//   BLOCK_BYTES : bytes per AES block (AES_BLOCK_W / 8)
//   CNT_W       : width of the in-block byte counter
package aes_sram_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } wr_state_t;

endpackage

// File: rtl/blk_shift_reg.sv
// 128-bit block register that is loaded in parallel and drained MSB byte first.
//   clk        : system clock, rising edge
//   n_rst      : asynchronous reset, active low
//   load_i     : capture data_i (takes priority over shift_i)
//   shift_i    : shift left by one byte, zero filling the bottom
//   data_i     : block to load
//   byte_out_o : current top byte [127:120]
module blk_shift_reg
  import aes_sram_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [AES_BLOCK_W-1:0] data_i,
  output logic [7:0]             byte_out_o
);

  logic [AES_BLOCK_W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = {shift_q[AES_BLOCK_W-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign byte_out_o = shift_q[AES_BLOCK_W-1 -: 8];

endmodule

// File: rtl/sram_result_writer.sv
// Write-side SRAM controller for the AES datapath. Takes 128-bit result
// blocks from the AES core and writes them byte by byte to SRAM, starting at
// s_addr and ending with the write to loc (inclusive), then flags done.
//
// Parameters:
//   ADDR_BITS : SRAM address width; addresses wrap modulo 2**ADDR_BITS
//   (bytes per block is BLOCK_BYTES from aes_sram_pkg)
//
// Ports:
//   clk       in  system clock, rising edge
//   n_rst     in  asynchronous reset, active low
//   enable    in  level: high = run, low = abort to IDLE
//   s_addr    in  first write address, sampled when leaving IDLE
//   loc       in  last write address (inclusive), sampled with s_addr
//   blk_valid in  AES core presents a block
//   blk_data  in  result block, byte [127:120] written first
//   blk_ready out writer can take a block this cycle
//   sram_wait in  SRAM stall; current write is held while high
//   w_en      out SRAM write strobe
//   w_addr    out SRAM write address
//   w_data    out SRAM write byte
//   done      out write to loc accepted; held until enable goes low
//   trunc     out loc was reached before the end of a block; valid with done
//   w_par     out even parity of w_data (only with SRAM_WR_PARITY_EN)
//
// Build option: define SRAM_WR_PARITY_EN to add the w_par output.
//
// Handshakes: a block moves on a cycle with blk_valid && blk_ready, and a
// byte write is accepted on a cycle with w_en && !sram_wait. Once raised,
// w_en/w_addr/w_data stay stable until the write is accepted (or the run is
// aborted). All outputs decode from registers only.
module sram_result_writer
  import aes_sram_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable,
  input  logic [ADDR_BITS-1:0]   s_addr,
  input  logic [ADDR_BITS-1:0]   loc,
  input  logic                   blk_valid,
  input  logic [AES_BLOCK_W-1:0] blk_data,
  output logic                   blk_ready,
  input  logic                   sram_wait,
  output logic                   w_en,
  output logic [ADDR_BITS-1:0]   w_addr,
  output logic [7:0]             w_data,
  output logic                   done,
  output logic                   trunc
`ifdef SRAM_WR_PARITY_EN
  ,
  output logic                   w_par
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

  wr_state_t            state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] end_q, end_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 trunc_q, trunc_d;
  logic                 sr_load, sr_shift;
  logic [7:0]           sr_byte;

  blk_shift_reg u_shift (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .data_i     (blk_data),
    .byte_out_o (sr_byte)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    if (!enable) begin
      // Abort from any state; a partly written block is simply dropped.
      state_d = IDLE;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ptr_d   = s_addr;
          end_d   = loc;
          state_d = WAIT_BLK;
        end
        WAIT_BLK: begin
          if (blk_valid) begin
            sr_load = 1'b1;
            cnt_d   = '0;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (!sram_wait) begin
            sr_shift = 1'b1;
            ptr_d    = ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            // The end address wins over the block boundary; any bytes left
            // in the block are dropped and reported through trunc.
            if (ptr_q == end_q) begin
              state_d = DONE;
              trunc_d = (cnt_q != LAST_CNT);
            end else if (cnt_q == LAST_CNT) begin
              state_d = WAIT_BLK;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign blk_ready = (state_q == WAIT_BLK);
  assign w_en      = (state_q == WRITE);
  assign w_addr    = ptr_q;
  assign w_data    = sr_byte;
  assign done      = (state_q == DONE);
  assign trunc     = trunc_q;

`ifdef SRAM_WR_PARITY_EN
  // Derived from the same register byte as w_data, so it tracks w_data
  // cycle for cycle and is 0 out of reset.
  assign w_par = ^sr_byte;
`endif

endmodule

// File: tb/tb_sram_result_writer.sv
// Self-checking bench for sram_result_writer. Expected SRAM writes are
// queued as {addr, data} when a block is driven and popped by a monitor
// whenever the DUT completes a write.
module tb_sram_result_writer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         enable;
  logic [7:0]   s_addr;
  logic [7:0]   loc;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic         sram_wait;
  logic         w_en;
  logic [7:0]   w_addr;
  logic [7:0]   w_data;
  logic         done;
  logic         trunc;
`ifdef SRAM_WR_PARITY_EN
  logic         w_par;
`endif

  int           total = 0;
  int           bad = 0;
  logic [15:0]  exp_q[$];
  logic [15:0]  mon_exp;
  logic [7:0]   m_ptr;
  int           cyc = 0;
  int           last_wr = -1;
  int           gap_max = 0;
  logic [127:0] blk;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_result_writer #(.ADDR_BITS(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .enable    (enable),
    .s_addr    (s_addr),
    .loc       (loc),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .sram_wait (sram_wait),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .done      (done),
    .trunc     (trunc)
`ifdef SRAM_WR_PARITY_EN
    ,
    .w_par     (w_par)
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (n_rst && w_en && !sram_wait) begin
      if (last_wr >= 0 && (cyc - last_wr) > gap_max) gap_max = cyc - last_wr;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'(exp_q.size()), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr", {16'h0, w_addr, w_data}, {16'h0, mon_exp});
`ifdef SRAM_WR_PARITY_EN
        check("par", w_par, ^mon_exp[7:0]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_block(input logic [127:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({m_ptr, data[127-8*i -: 8]});
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    blk_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] l);
    s_addr = s;
    loc = l;
    m_ptr = s;
    enable = 1'b1;
    @(posedge clk); #1;
    gap_max = 0;
    last_wr = -1;
  endtask

  task automatic send_block(input logic [127:0] data);
    logic ok;
    ok = 1'b0;
    blk_data = data;
    blk_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    check("xfer", ok, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done", done, 1);
  endtask

  task automatic wait_writes(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_en && !sram_wait) cnt++;
      if (cnt == n) break;
    end
    check("wr_count", cnt, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_rst = 1'b0;
    enable = 1'b0;
    s_addr = '0;
    loc = '0;
    blk_valid = 1'b0;
    blk_data = '0;
    sram_wait = 1'b0;
    m_ptr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", w_en, 0);
    check("rst_rdy", blk_ready, 0);
    check("rst_done", done, 0);
    check("rst_trunc", trunc, 0);
    check("rst_addr", w_addr, 0);
    check("rst_data", w_data, 0);
`ifdef SRAM_WR_PARITY_EN
    check("rst_par", w_par, 0);
`endif
    @(posedge clk); #1;
    n_rst = 1'b1;

    // 1: single full block 0x00..0x0F
    start(8'h00, 8'h0F);
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    expect_block(blk, 16);
    send_block(blk);
    @(negedge clk);
    check("t1_rdy_low", blk_ready, 0);
    check("t1_wen", w_en, 1);
    wait_done(100);
    check("t1_trunc", trunc, 0);
    check("t1_done_wen", w_en, 0);
    check("t1_done_rdy", blk_ready, 0);
    check("t1_sb", 32'(exp_q.size()), 0);
    check("t1_gap", gap_max, 1);
    stop_run();
    @(negedge clk);
    check("t1_done_clr", done, 0);

    // 2: two blocks back to back, 0x10..0x2F
    start(8'h10, 8'h2F);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 16);
    send_block(blk);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 16);
    send_block(blk);
    wait_done(100);
    check("t2_trunc", trunc, 0);
    check("t2_sb", 32'(exp_q.size()), 0);
    check("t2_gap", gap_max, 2);
    stop_run();

    // 3: address wrap 0xF8..0x07
    start(8'hF8, 8'h07);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 16);
    send_block(blk);
    wait_done(100);
    check("t3_trunc", trunc, 0);
    check("t3_sb", 32'(exp_q.size()), 0);
    stop_run();

    // 4: three-cycle stall on the 5th byte
    start(8'h30, 8'h3F);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 16);
    send_block(blk);
    wait_writes(4);
    @(posedge clk); #1;
    sram_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_wen", w_en, 1);
      check("t4_hold_addr", w_addr, 8'h34);
      check("t4_hold_data", w_data, blk[95 -: 8]);
      @(posedge clk); #1;
    end
    sram_wait = 1'b0;
    wait_done(100);
    check("t4_sb", 32'(exp_q.size()), 0);
    stop_run();

    // 5: short range 0x40..0x44 -> truncated, later blocks ignored
    start(8'h40, 8'h44);
    blk = {8'h07, 8'h81, 8'hFF, 8'h00, 8'h3C, 88'($urandom)};
    expect_block(blk, 5);
    send_block(blk);
    wait_done(100);
    check("t5_trunc", trunc, 1);
    check("t5_sb", 32'(exp_q.size()), 0);
    blk_data = {$urandom, $urandom, $urandom, $urandom};
    blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_rdy_low", blk_ready, 0);
      check("t5_done_hold", done, 1);
    end
    blk_valid = 1'b0;
    stop_run();
    @(negedge clk);
    check("t5_trunc_clr", trunc, 0);

    // 6: abort after 7th byte, restart at 0x80
    start(8'h60, 8'h6F);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 7);
    send_block(blk);
    wait_writes(7);
    enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_abort_wen", w_en, 0);
    check("t6_abort_rdy", blk_ready, 0);
    check("t6_abort_done", done, 0);
    check("t6_sb", 32'(exp_q.size()), 0);
    start(8'h80, 8'h8F);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 16);
    send_block(blk);
    wait_done(100);
    check("t6_trunc", trunc, 0);
    check("t6_sb2", 32'(exp_q.size()), 0);
    stop_run();

    // 7: single byte range s_addr == loc
    start(8'hA5, 8'hA5);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 1);
    send_block(blk);
    wait_done(100);
    check("t7_trunc", trunc, 1);
    check("t7_sb", 32'(exp_q.size()), 0);
    stop_run();

    // 8: reset asserted mid-write
    start(8'hC0, 8'hCF);
    blk = {$urandom, $urandom, $urandom, $urandom};
    expect_block(blk, 3);
    send_block(blk);
    wait_writes(3);
    @(posedge clk); #1;
    n_rst = 1'b0;
    enable = 1'b0;
    #1;
    check("t8_rst_wen", w_en, 0);
    check("t8_rst_addr", w_addr, 0);
    check("t8_rst_data", w_data, 0);
    check("t8_sb", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
